// File: rtl/gol_pkg.sv
// Shared definitions for the grid scan-out block.
//   scan_state_e : scan FSM state encoding (IDLE / STREAM / DONE)
//   calc_cw      : column counter width, max(1, clog2(cols))
//   calc_rw      : row counter width, max(1, clog2(rows))
//   calc_nw      : live-cell count width, clog2(rows*cols + 1)
`timescale 1ns/1ps
package gol_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } scan_state_e;

    function automatic int unsigned calc_cw(input int unsigned cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int unsigned calc_rw(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Needs to hold the value rows*cols itself (all cells live).
    function automatic int unsigned calc_nw(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols + 1);
    endfunction

endpackage

// File: rtl/grid_scan_out_if.sv
// Cell stream interface of the grid scan-out block.
//   out_valid : beat available (source -> sink)
//   out_ready : sink accepts beat (sink -> source)
//   out_cell  : state of the current cell
//   out_col   : column of the current cell
//   out_row   : row of the current cell
//   out_sof   : current beat is cell (0,0)
//   out_eof   : current beat is the last cell of the grid
// Modports: master = stream source, slave = stream sink.
`timescale 1ns/1ps
interface grid_scan_out_if
    import gol_pkg::*;
#(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 8
) ();

    localparam int unsigned CW = calc_cw(COLS);
    localparam int unsigned RW = calc_rw(ROWS);

    logic          out_valid;
    logic          out_ready;
    logic          out_cell;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          out_sof;
    logic          out_eof;

    modport master (
        output out_valid,
        output out_cell,
        output out_col,
        output out_row,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_cell,
        input  out_col,
        input  out_row,
        input  out_sof,
        input  out_eof,
        output out_ready
    );

endinterface

// File: rtl/gol_dff.sv
// Plain D flip-flop bank with asynchronous active-low reset.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads INITVAL
//   d     : next value, captured every posedge
//   q     : registered value
`timescale 1ns/1ps
module gol_dff #(
    parameter int unsigned    W       = 1,
    parameter logic [W-1:0]   INITVAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INITVAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/grid_scan_out.sv
// Snapshots a ROWS x COLS cell grid on start and streams it out one cell per
// beat in row-major order over a valid/ready interface, then pulses done and
// publishes the number of live cells in the frame.
//   clk        : clock, all state changes on posedge
//   _rst       : asynchronous active-low reset
//   start      : capture the grid and begin a frame (sampled only when idle)
//   grid       : live cell states, bit r*COLS+c = cell (r, c)
//   busy       : high from the capture cycle through the done cycle
//   done       : one-cycle pulse after the last beat transfers
//   live_count : live cells in the last completed frame
//   strm       : cell stream (master side)
`timescale 1ns/1ps
module grid_scan_out
    import gol_pkg::*;
#(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 8,
    localparam int unsigned CW    = calc_cw(COLS),
    localparam int unsigned RW    = calc_rw(ROWS),
    localparam int unsigned NW    = calc_nw(ROWS, COLS),
    localparam int unsigned NCELL = ROWS * COLS
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             start,
    input  logic [NCELL-1:0] grid,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    live_count,
    grid_scan_out_if.master  strm
);

    scan_state_e      state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [NW-1:0]    live_q, live_d;
    logic             snap_load;
    logic [NCELL-1:0] snap_q, snap_d;
    logic [NCELL-1:0] snap_shifted;
    logic [NW-1:0]    cell_idx;
    logic             cur_cell;
    logic             valid;
    logic             last;
    logic             first;
    logic             xfer;

    // Frame snapshot: reloaded only on the capture edge, so grid changes
    // during a frame never reach the stream.
    assign snap_d = snap_load ? grid : snap_q;

    gol_dff #(
        .W       (NCELL),
        .INITVAL ('0)
    ) u_snap (
        .clk   (clk),
        .rst_n (_rst),
        .d     (snap_d),
        .q     (snap_q)
    );

    // Shift rather than index so the select width never depends on NW.
    assign cell_idx     = NW'(row_q) * NW'(COLS) + NW'(col_q);
    assign snap_shifted = snap_q >> cell_idx;
    assign cur_cell     = snap_shifted[0];

    assign valid = (state_q == StStream);
    assign first = (row_q == '0) && (col_q == '0);
    assign last  = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    assign xfer  = valid && strm.out_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        live_d    = live_q;
        snap_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStream;
                    snap_load = 1'b1;
                    col_d     = '0;
                    row_d     = '0;
                    cnt_d     = '0;
                end
            end
            StStream: begin
                if (xfer) begin
                    if (cur_cell) begin
                        cnt_d = cnt_q + NW'(1);
                    end
                    if (last) begin
                        state_d = StDone;
                        live_d  = cnt_q + NW'(cur_cell);
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            live_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
        end
    end

    // Beat fields are forced to zero whenever no beat is presented.
    assign strm.out_valid = valid;
    assign strm.out_cell  = valid & cur_cell;
    assign strm.out_col   = valid ? col_q : '0;
    assign strm.out_row   = valid ? row_q : '0;
    assign strm.out_sof   = valid & first;
    assign strm.out_eof   = valid & last;

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign live_count = live_q;

endmodule

// File: tb/tb_grid_scan_out.sv
`timescale 1ns/1ps
module tb_grid_scan_out;

    logic        clk = 1'b0;
    logic        _rst = 1'b0;
    logic [3:0]  start_v = '0;
    logic [3:0]  ready_v = '0;
    logic [63:0] grid_w = '0;

    logic busy44, done44, busy88, done88, busy11, done11, busy35, done35;
    logic [4:0]  live44;
    logic [6:0]  live88;
    logic [0:0]  live11;
    logic [3:0]  live35;

    int tests = 0;
    int fails = 0;
    int sel = 0;

    int obs_valid, obs_cell, obs_col, obs_row, obs_sof, obs_eof;
    int obs_busy, obs_done, obs_live;

    always #5 clk = ~clk;

    grid_scan_out_if #(.COLS(4), .ROWS(4)) if44 ();
    grid_scan_out_if #(.COLS(8), .ROWS(8)) if88 ();
    grid_scan_out_if #(.COLS(1), .ROWS(1)) if11 ();
    grid_scan_out_if #(.COLS(5), .ROWS(3)) if35 ();

    assign if44.out_ready = ready_v[0];
    assign if88.out_ready = ready_v[1];
    assign if11.out_ready = ready_v[2];
    assign if35.out_ready = ready_v[3];

    grid_scan_out #(.COLS(4), .ROWS(4)) u_dut44 (
        .clk(clk), ._rst(_rst), .start(start_v[0]), .grid(grid_w[15:0]),
        .busy(busy44), .done(done44), .live_count(live44), .strm(if44)
    );
    grid_scan_out #(.COLS(8), .ROWS(8)) u_dut88 (
        .clk(clk), ._rst(_rst), .start(start_v[1]), .grid(grid_w[63:0]),
        .busy(busy88), .done(done88), .live_count(live88), .strm(if88)
    );
    grid_scan_out #(.COLS(1), .ROWS(1)) u_dut11 (
        .clk(clk), ._rst(_rst), .start(start_v[2]), .grid(grid_w[0:0]),
        .busy(busy11), .done(done11), .live_count(live11), .strm(if11)
    );
    grid_scan_out #(.COLS(5), .ROWS(3)) u_dut35 (
        .clk(clk), ._rst(_rst), .start(start_v[3]), .grid(grid_w[14:0]),
        .busy(busy35), .done(done35), .live_count(live35), .strm(if35)
    );

    // Observation mux: one view of whichever instance is under test.
    always_comb begin
        obs_valid = 0; obs_cell = 0; obs_col = 0; obs_row = 0; obs_sof = 0;
        obs_eof = 0; obs_busy = 0; obs_done = 0; obs_live = 0;
        case (sel)
            0: begin
                obs_valid = int'(if44.out_valid); obs_cell = int'(if44.out_cell);
                obs_col = int'(if44.out_col); obs_row = int'(if44.out_row);
                obs_sof = int'(if44.out_sof); obs_eof = int'(if44.out_eof);
                obs_busy = int'(busy44); obs_done = int'(done44); obs_live = int'(live44);
            end
            1: begin
                obs_valid = int'(if88.out_valid); obs_cell = int'(if88.out_cell);
                obs_col = int'(if88.out_col); obs_row = int'(if88.out_row);
                obs_sof = int'(if88.out_sof); obs_eof = int'(if88.out_eof);
                obs_busy = int'(busy88); obs_done = int'(done88); obs_live = int'(live88);
            end
            2: begin
                obs_valid = int'(if11.out_valid); obs_cell = int'(if11.out_cell);
                obs_col = int'(if11.out_col); obs_row = int'(if11.out_row);
                obs_sof = int'(if11.out_sof); obs_eof = int'(if11.out_eof);
                obs_busy = int'(busy11); obs_done = int'(done11); obs_live = int'(live11);
            end
            default: begin
                obs_valid = int'(if35.out_valid); obs_cell = int'(if35.out_cell);
                obs_col = int'(if35.out_col); obs_row = int'(if35.out_row);
                obs_sof = int'(if35.out_sof); obs_eof = int'(if35.out_eof);
                obs_busy = int'(busy35); obs_done = int'(done35); obs_live = int'(live35);
            end
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (dut %0d): observed %0d expected %0d", tag, sel, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input int exp_live);
        chk({tag, "_valid"}, obs_valid, 0);
        chk({tag, "_busy"}, obs_busy, 0);
        chk({tag, "_done"}, obs_done, 0);
        chk({tag, "_cell"}, obs_cell, 0);
        chk({tag, "_sof"}, obs_sof, 0);
        chk({tag, "_eof"}, obs_eof, 0);
        chk({tag, "_live"}, obs_live, exp_live);
    endtask

    // Reference: a frame is the captured grid read in row-major order; beat i
    // is cell i, at (i / cols, i % cols); live_count is the popcount.
    task automatic run_frame(input int s, input int cols, input int rows,
                             input logic [63:0] g, input bit rand_ready,
                             input bit disturb, input int abort_at);
        int  n, pop, beat, cyc;
        bit  rdy;
        n   = cols * rows;
        pop = 0;
        for (int i = 0; i < n; i++) pop += int'(g[i]);
        sel        = s;
        grid_w     = g;
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < n && cyc < 8 * n + 16) begin
            if (disturb) begin
                grid_w     = '1;
                start_v[s] = 1'($urandom_range(0, 1));
            end
            chk("valid", obs_valid, 1);
            chk("busy", obs_busy, 1);
            chk("done_early", obs_done, 0);
            chk("cell", obs_cell, int'(g[beat]));
            chk("col", obs_col, beat % cols);
            chk("row", obs_row, beat / cols);
            chk("sof", obs_sof, int'(beat == 0));
            chk("eof", obs_eof, int'(beat == n - 1));
            if (beat == abort_at) begin
                _rst = 1'b0;
                #1;
                chk_idle_outputs("abort", 0);
                chk("abort_col", obs_col, 0);
                chk("abort_row", obs_row, 0);
                @(negedge clk);
                chk("abort_no_done", obs_done, 0);
                chk("abort_no_valid", obs_valid, 0);
                _rst       = 1'b1;
                start_v[s] = 1'b0;
                ready_v[s] = 1'b0;
                return;
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_v[s] = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) beat++;
        end
        chk("frame_len", beat, n);
        start_v[s] = 1'b0;
        ready_v[s] = 1'b0;
        chk("done_pulse", obs_done, 1);
        chk("done_busy", obs_busy, 1);
        chk("done_valid", obs_valid, 0);
        chk("done_cell", obs_cell, 0);
        chk("done_sof", obs_sof, 0);
        chk("done_eof", obs_eof, 0);
        chk("done_live", obs_live, pop);
        @(negedge clk);
        chk_idle_outputs("post", pop);
    endtask

    initial begin
        logic [63:0] g;
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk_idle_outputs("reset", 0);
            chk("reset_col", obs_col, 0);
            chk("reset_row", obs_row, 0);
        end
        @(negedge clk);
        _rst = 1'b1;

        // 4x4 corners only, always ready: 16 back-to-back beats, live_count 2.
        run_frame(0, 4, 4, 64'h8001, 1'b0, 1'b0, -1);
        // 4x4 random pattern with back-pressure.
        g = {$urandom, $urandom};
        run_frame(0, 4, 4, g, 1'b1, 1'b0, -1);
        // 4x4 with grid forced to ones and start poked during the frame.
        g = {$urandom, $urandom};
        run_frame(0, 4, 4, g, 1'b1, 1'b1, -1);
        // 3x5 all ones: column wrap 4 -> 0, live_count 15.
        run_frame(3, 5, 3, 64'h7fff, 1'b1, 1'b0, -1);
        // 1x1: single beat carries both sof and eof.
        run_frame(2, 1, 1, 64'h1, 1'b0, 1'b0, -1);
        run_frame(2, 1, 1, 64'h0, 1'b1, 1'b0, -1);
        // 8x8: reset at beat 5 aborts, then a fresh frame from (0,0).
        g = {$urandom, $urandom};
        run_frame(1, 8, 8, g, 1'b0, 1'b0, 5);
        g = {$urandom, $urandom};
        run_frame(1, 8, 8, g, 1'b1, 1'b0, -1);
        for (int k = 0; k < 3; k++) begin
            g = {$urandom, $urandom};
            run_frame(1, 8, 8, g, 1'b1, 1'(k == 1), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grid_scan_out.md
GRID_SCAN_OUT -- requirements
Module: grid_scan_out

Interface
REQ-001 Parameter COLS, default 8: grid width in cells, legal range 1..64.
REQ-002 Parameter ROWS, default 8: grid height in cells, legal range 1..64.
REQ-003 Derived widths: CW = max(1,clog2(COLS)), RW = max(1,clog2(ROWS)), NW = clog2(ROWS*COLS+1).
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 _rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to snapshot the grid and stream it out.
REQ-007 grid  input  ROWS*COLS  live cell states; bit r*COLS+c = cell (row r, col c).
REQ-008 busy  output  1  high from the capture cycle through the done cycle.
REQ-009 out_valid  output  1  beat available.
REQ-010 out_ready  input  1  consumer accepts beat.
REQ-011 out_cell  output  1  state of the current cell.
REQ-012 out_col  output  CW  column of the current cell.
REQ-013 out_row  output  RW  row of the current cell.
REQ-014 out_sof  output  1  current beat is cell (0,0).
REQ-015 out_eof  output  1  current beat is cell (ROWS-1,COLS-1).
REQ-016 done  output  1  one-cycle pulse after the last beat transfers.
REQ-017 live_count  output  NW  number of live cells in the last completed frame.

Function
REQ-018 States: IDLE, STREAM, DONE; encoding local to the block.
REQ-019 IDLE: start=1 at a posedge copies grid into an internal snapshot register, clears the row/col counters and the running count, and enters STREAM.
REQ-020 Latency: out_valid is 1 in the cycle immediately after the capture edge, presenting cell (0,0) with out_sof=1.
REQ-021 Transfer occurs on a posedge where out_valid=1 and out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_cell, out_col, out_row, out_sof and out_eof hold stable.
REQ-023 On a non-last transfer: col increments; at col=COLS-1, col wraps to 0 and row increments.
REQ-024 On the last transfer (out_eof=1): enter DONE; out_valid=0 in the following cycle.
REQ-025 DONE lasts exactly one cycle with done=1 and busy=1, then returns to IDLE.
REQ-026 The running count increments on each transfer where out_cell=1; at the last transfer the final value is stored to live_count, which holds until the next last transfer.
REQ-027 start is ignored in STREAM and DONE; it is sampled only in IDLE.
REQ-028 Changes on grid after the capture edge do not affect the frame in progress.
REQ-029 ROWS=COLS=1: the single beat has out_sof=1 and out_eof=1.
REQ-030 While out_valid=0: out_cell, out_sof and out_eof are 0.

Reset
REQ-031 _rst=0 asynchronously forces IDLE, clears the snapshot, counters and running count, and sets every output to 0 (including live_count).
REQ-032 Reset during STREAM aborts the frame without a done pulse; the first start after reset release begins a fresh frame at (0,0).

Structure
REQ-033 Shared package gol_pkg holds the state encoding constants and the CW/RW/NW width functions.
REQ-034 The snapshot register is one instance of the existing D flip-flop module with W=ROWS*COLS and INITVAL=0, fed by a hold/load mux.

Verification
REQ-035 4x4 grid=16'h8001, start pulse, out_ready=1 -> 16 beats on consecutive cycles, sof on (0,0), eof on (3,3), cell=1 only at beats 0 and 15, done one cycle later, live_count=2.
REQ-036 out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, outputs stable while stalled, beat order unchanged.
REQ-037 Flip grid to all ones mid-frame -> streamed values match the captured pattern; start pulses during STREAM are ignored and busy stays 1.
REQ-038 _rst low at beat 5 of an 8x8 frame -> outputs go to 0 immediately, no done pulse; next start streams from (0,0).
REQ-039 ROWS=COLS=1, grid=1 -> single beat with sof=eof=1, then done, live_count=1.
REQ-040 3x5 grid all ones -> col wraps 4->0 with row increment, live_count=15.
